// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - Round-robin writeback arbiter merging two write queues into one register-file port
//
// Purpose:
//   Two requesters (A = ALU, B = load unit) each push {rd, data} into their own
//   FIFO. Each cycle the non-empty queue heads are arbitrated round-robin and
//   the winner is popped straight into the registered register-file write
//   stage (rf_we / rf_rw / rf_busw). Writes to x0 consume their slot and their
//   arbitration turn, but leave rf_we low.
//
// Optional feature:
//   REG_WB_ARBITER_BYPASS_EN - adds a combinational lookup port (q_addr ->
//   q_hit / q_data) that searches the queued entries and the output stage for
//   the newest pending value of a register.
//
// Ports (reg_wb_arbiter):
//   clk               sole clock, rising edge
//   rst_n             asynchronous active-low reset
//   a_valid/a_ready   requester A handshake; a_ready = A queue not full
//   a_rd, a_data      requester A destination register and write data
//   b_valid/b_ready   requester B handshake; b_ready = B queue not full
//   b_rd, b_data      requester B destination register and write data
//   rf_we             register-file write enable (registered)
//   rf_rw             register-file write address (registered)
//   rf_busw           register-file write data (registered)
//   busy              any entry queued or a write in the output stage
//   q_addr            (bypass only) register to look up
//   q_hit             (bypass only) a pending write to q_addr exists
//   q_data            (bypass only) newest pending value, zero on miss
//
// Ports (reg_wb_arbiter_fifo):
//   i_push/i_pop      push and pop strobes; caller guarantees !full / !empty
//   i_rd, i_data      entry written on push
//   o_full, o_empty   occupancy flags, registered-state derived only
//   o_head_rd/_data   oldest entry
//   i_q_addr          (bypass only) lookup register
//   o_q_hit/o_q_data  (bypass only) youngest matching queued entry

module reg_wb_arbiter_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_data,
    input  logic        i_pop,
    output logic        o_full,
    output logic        o_empty,
    output logic [4:0]  o_head_rd,
    output logic [31:0] o_head_data
`ifdef REG_WB_ARBITER_BYPASS_EN
    ,
    input  logic [4:0]  i_q_addr,
    output logic        o_q_hit,
    output logic [31:0] o_q_data
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;

    // Pointers wrap naturally because DEPTH is a power of two; the separate
    // count tells full from empty when the pointers are equal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: validity is carried entirely by r_cnt.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem_rd[r_wr_ptr]   <= i_rd;
            r_mem_data[r_wr_ptr] <= i_data;
        end
    end

    assign o_full      = (r_cnt == CW'(DEPTH));
    assign o_empty     = (r_cnt == '0);
    assign o_head_rd   = r_mem_rd[r_rd_ptr];
    assign o_head_data = r_mem_data[r_rd_ptr];

`ifdef REG_WB_ARBITER_BYPASS_EN
    logic [AW-1:0] w_idx;

    // Walk valid entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        o_q_hit  = 1'b0;
        o_q_data = '0;
        w_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + AW'(i);
            if ((CW'(i) < r_cnt) && (r_mem_rd[w_idx] == i_q_addr)) begin
                o_q_hit  = 1'b1;
                o_q_data = r_mem_data[w_idx];
            end
        end
    end
`endif

endmodule

module reg_wb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        rf_we,
    output logic [4:0]  rf_rw,
    output logic [31:0] rf_busw,
    output logic        busy
`ifdef REG_WB_ARBITER_BYPASS_EN
    ,
    input  logic [4:0]  q_addr,
    output logic        q_hit,
    output logic [31:0] q_data
`endif
);

    logic        w_a_push;
    logic        w_b_push;
    logic        w_a_full;
    logic        w_b_full;
    logic        w_a_empty;
    logic        w_b_empty;
    logic [4:0]  w_a_head_rd;
    logic [4:0]  w_b_head_rd;
    logic [31:0] w_a_head_data;
    logic [31:0] w_b_head_data;
    logic        w_grant_a;
    logic        w_grant_b;
    logic [4:0]  w_win_rd;
    logic [31:0] w_win_data;

    logic        r_rf_we;
    logic [4:0]  r_rf_rw;
    logic [31:0] r_rf_busw;
    // Set when A won the last grant, so B is favoured on the next contention.
    logic        r_prio_b;

    // Ready comes only from registered occupancy, so a pop in the same cycle
    // never lets a full queue accept.
    assign a_ready  = !w_a_full;
    assign b_ready  = !w_b_full;
    assign w_a_push = a_valid && !w_a_full;
    assign w_b_push = b_valid && !w_b_full;

`ifdef REG_WB_ARBITER_BYPASS_EN
    logic        w_a_hit;
    logic        w_b_hit;
    logic [31:0] w_a_qdata;
    logic [31:0] w_b_qdata;
    logic        w_out_hit;
`endif

    reg_wb_arbiter_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_a_push),
        .i_rd        (a_rd),
        .i_data      (a_data),
        .i_pop       (w_grant_a),
        .o_full      (w_a_full),
        .o_empty     (w_a_empty),
        .o_head_rd   (w_a_head_rd),
        .o_head_data (w_a_head_data)
`ifdef REG_WB_ARBITER_BYPASS_EN
        ,
        .i_q_addr    (q_addr),
        .o_q_hit     (w_a_hit),
        .o_q_data    (w_a_qdata)
`endif
    );

    reg_wb_arbiter_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_b_push),
        .i_rd        (b_rd),
        .i_data      (b_data),
        .i_pop       (w_grant_b),
        .o_full      (w_b_full),
        .o_empty     (w_b_empty),
        .o_head_rd   (w_b_head_rd),
        .o_head_data (w_b_head_data)
`ifdef REG_WB_ARBITER_BYPASS_EN
        ,
        .i_q_addr    (q_addr),
        .o_q_hit     (w_b_hit),
        .o_q_data    (w_b_qdata)
`endif
    );

    // Round-robin: A wins unless B also has work and A won last time.
    always_comb begin
        w_grant_a  = !w_a_empty && (w_b_empty || !r_prio_b);
        w_grant_b  = !w_b_empty && !w_grant_a;
        w_win_rd   = w_grant_a ? w_a_head_rd   : w_b_head_rd;
        w_win_data = w_grant_a ? w_a_head_data : w_b_head_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we   <= 1'b0;
            r_rf_rw   <= '0;
            r_rf_busw <= '0;
            r_prio_b  <= 1'b0;
        end else if (w_grant_a || w_grant_b) begin
            // An x0 entry still loads the stage and uses its turn, but never writes.
            r_rf_we   <= (w_win_rd != 5'd0);
            r_rf_rw   <= w_win_rd;
            r_rf_busw <= w_win_data;
            r_prio_b  <= w_grant_a;
        end else begin
            r_rf_we   <= 1'b0;
        end
    end

    assign rf_we   = r_rf_we;
    assign rf_rw   = r_rf_rw;
    assign rf_busw = r_rf_busw;
    assign busy    = !w_a_empty || !w_b_empty || r_rf_we;

`ifdef REG_WB_ARBITER_BYPASS_EN
    assign w_out_hit = r_rf_we && (r_rf_rw == q_addr);

    always_comb begin
        q_hit  = (q_addr != 5'd0) && (w_a_hit || w_b_hit || w_out_hit);
        q_data = '0;
        if (q_hit) begin
            if (w_a_hit) begin
                q_data = w_a_qdata;
            end else if (w_b_hit) begin
                q_data = w_b_qdata;
            end else begin
                q_data = r_rf_busw;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - Self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_busw;
    logic        busy;
`ifdef REG_WB_ARBITER_BYPASS_EN
    logic [4:0]  q_addr;
    logic        q_hit;
    logic [31:0] q_data;
`endif

    int total;
    int bad;

    reg_wb_arbiter #(
        .FIFO_DEPTH (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_rd    (a_rd),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_rd    (b_rd),
        .b_data  (b_data),
        .rf_we   (rf_we),
        .rf_rw   (rf_rw),
        .rf_busw (rf_busw),
        .busy    (busy)
`ifdef REG_WB_ARBITER_BYPASS_EN
        ,
        .q_addr  (q_addr),
        .q_hit   (q_hit),
        .q_data  (q_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bdata;
        logic        we;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic        ar;
        logic        br;
        logic        bsy;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];

    logic [36:0] qa [$];
    logic [36:0] qb [$];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adata,
                                logic bv, logic [4:0] brd, logic [31:0] bdata,
                                logic we, logic [4:0] rw, logic [31:0] busw,
                                logic ar, logic br, logic bsy);
        vec_t v;
        v.av = av; v.ard = ard; v.adata = adata;
        v.bv = bv; v.brd = brd; v.bdata = bdata;
        v.we = we; v.rw = rw; v.busw = busw;
        v.ar = ar; v.br = br; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bdata);
        a_valid = av; a_rd = ard; a_data = adata;
        b_valid = bv; b_rd = brd; b_data = bdata;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Each visible write is attributed to its requester by address range
    // (A uses 1..15, B uses 16..31) and checked against that requester's order.
    task automatic monitor_write();
        logic [36:0] e;
        if (rf_we) begin
            if (rf_rw < 5'd16) begin
                if (qa.size() == 0) begin
                    chk("sb_a_unexpected", {27'd0, rf_rw, rf_busw}, 64'd0);
                end else begin
                    e = qa.pop_front();
                    chk("sb_a_write", {27'd0, rf_rw, rf_busw}, {27'd0, e});
                end
            end else begin
                if (qb.size() == 0) begin
                    chk("sb_b_unexpected", {27'd0, rf_rw, rf_busw}, 64'd0);
                end else begin
                    e = qb.pop_front();
                    chk("sb_b_write", {27'd0, rf_rw, rf_busw}, {27'd0, e});
                end
            end
        end
    endtask

    initial begin
        logic acc_a;
        logic acc_b;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
`ifdef REG_WB_ARBITER_BYPASS_EN
        q_addr = 5'd0;
`endif

        //        A valid/rd/data          B valid/rd/data            we rw    busw          ar br busy
        tbl[0]  = mk(1, 5'd1, 32'h11,       1, 5'd2,  32'h22,         0, 5'd0,  32'h0,        1, 1, 1);
        tbl[1]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd1,  32'h11,       1, 1, 1);
        tbl[2]  = mk(1, 5'd3, 32'h33,       1, 5'd4,  32'h44,         1, 5'd2,  32'h22,       1, 1, 1);
        tbl[3]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd3,  32'h33,       1, 1, 1);
        tbl[4]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd4,  32'h44,       1, 1, 1);
        tbl[5]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd4,  32'h44,       1, 1, 0);
        tbl[6]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0,  32'h0,          0, 5'd4,  32'h44,       1, 1, 1);
        tbl[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd5,  32'hDEADBEEF, 1, 1, 1);
        tbl[8]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd5,  32'hDEADBEEF, 1, 1, 0);
        tbl[9]  = mk(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0,  32'h0,          0, 5'd5,  32'hDEADBEEF, 1, 1, 1);
        tbl[10] = mk(1, 5'd6, 32'h66,       0, 5'd0,  32'h0,          0, 5'd0,  32'hFFFFFFFF, 1, 1, 1);
        tbl[11] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd6,  32'h66,       1, 1, 1);
        tbl[12] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd6,  32'h66,       1, 1, 0);
        tbl[13] = mk(1, 5'd7, 32'h71,       1, 5'd17, 32'hB1,         0, 5'd6,  32'h66,       1, 1, 1);
        tbl[14] = mk(1, 5'd8, 32'h72,       1, 5'd18, 32'hB2,         1, 5'd17, 32'hB1,       0, 1, 1);
        tbl[15] = mk(1, 5'd9, 32'h73,       0, 5'd0,  32'h0,          1, 5'd7,  32'h71,       1, 1, 1);
        tbl[16] = mk(1, 5'd9, 32'h73,       0, 5'd0,  32'h0,          1, 5'd18, 32'hB2,       0, 1, 1);
        tbl[17] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd8,  32'h72,       1, 1, 1);
        tbl[18] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          1, 5'd9,  32'h73,       1, 1, 1);
        tbl[19] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,          0, 5'd9,  32'h73,       1, 1, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",    {63'd0, rf_we},   64'd0);
        chk("rst_rw",    {59'd0, rf_rw},   64'd0);
        chk("rst_busw",  {32'd0, rf_busw}, 64'd0);
        chk("rst_busy",  {63'd0, busy},    64'd0);
        chk("rst_ready", {62'd0, a_ready, b_ready}, 64'd3);
        rst_n = 1'b1;

        // Directed table: row 0 lands on the first edge after reset release
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].av, tbl[i].ard, tbl[i].adata, tbl[i].bv, tbl[i].brd, tbl[i].bdata);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_we", i),      {63'd0, rf_we},   {63'd0, tbl[i].we});
            chk($sformatf("row%0d_rw", i),      {59'd0, rf_rw},   {59'd0, tbl[i].rw});
            chk($sformatf("row%0d_busw", i),    {32'd0, rf_busw}, {32'd0, tbl[i].busw});
            chk($sformatf("row%0d_a_ready", i), {63'd0, a_ready}, {63'd0, tbl[i].ar});
            chk($sformatf("row%0d_b_ready", i), {63'd0, b_ready}, {63'd0, tbl[i].br});
            chk($sformatf("row%0d_busy", i),    {63'd0, busy},    {63'd0, tbl[i].bsy});
        end
        idle();

        // Random traffic through the scoreboard
        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(1, 15)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(16, 31)), $urandom);
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            @(posedge clk);
            if (acc_a) qa.push_back({a_rd, a_data});
            if (acc_b) qb.push_back({b_rd, b_data});
            #1;
            monitor_write();
        end
        idle();
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            monitor_write();
        end
        chk("sb_a_drained", 64'(qa.size()), 64'd0);
        chk("sb_b_drained", 64'(qb.size()), 64'd0);
        chk("sb_idle_busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-cycle with two entries queued
        drive(1'b1, 5'd10, 32'hA0A0A0A0, 1'b1, 5'd20, 32'hB0B0B0B0);
        @(posedge clk);
        #1;
        idle();
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we",    {63'd0, rf_we},   64'd0);
        chk("async_rst_rw",    {59'd0, rf_rw},   64'd0);
        chk("async_rst_busw",  {32'd0, rf_busw}, 64'd0);
        chk("async_rst_busy",  {63'd0, busy},    64'd0);
        chk("async_rst_ready", {62'd0, a_ready, b_ready}, 64'd3);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("flushed_we_%0d", c),   {63'd0, rf_we}, 64'd0);
            chk($sformatf("flushed_busy_%0d", c), {63'd0, busy},  64'd0);
        end

        // Request waiting at reset release is taken on the very next edge
        rst_n = 1'b0;
        drive(1'b1, 5'd12, 32'h0000000C, 1'b0, 5'd0, 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        chk("first_edge_busy", {63'd0, busy}, 64'd1);
        chk("first_edge_we",   {63'd0, rf_we}, 64'd0);
        @(posedge clk);
        #1;
        chk("first_edge_write", {30'd0, rf_we, rf_rw, rf_busw}, {30'd0, 1'b1, 5'd12, 32'h0000000C});
        @(posedge clk);
        #1;

`ifdef REG_WB_ARBITER_BYPASS_EN
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
        @(posedge clk);
        #1;
        idle();
        q_addr = 5'd7;
        #1;
        chk("byp_hit",  {63'd0, q_hit},  64'd1);
        chk("byp_data", {32'd0, q_data}, 64'h77);
        q_addr = 5'd0;
        #1;
        chk("byp_x0_hit",  {63'd0, q_hit},  64'd0);
        chk("byp_x0_data", {32'd0, q_data}, 64'd0);
        q_addr = 5'd8;
        #1;
        chk("byp_miss", {63'd0, q_hit}, 64'd0);
        q_addr = 5'd0;
        repeat (3) @(posedge clk);
        #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, entries per requester queue; power of two, 2..8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port a_valid  input  1  requester A (ALU) write request.
REQ-005 SHALL have port a_ready  output  1  A queue can accept.
REQ-006 SHALL have port a_rd  input  5  A destination register.
REQ-007 SHALL have port a_data  input  32  A write data.
REQ-008 SHALL have ports b_valid/b_ready/b_rd/b_data with the same directions and widths as A; requester B is the load unit.
REQ-009 SHALL have port rf_we  output  1  register-file write enable.
REQ-010 SHALL have port rf_rw  output  5  register-file write address.
REQ-011 SHALL have port rf_busw  output  32  register-file write data.
REQ-012 SHALL have port busy  output  1  high while any queue entry is pending or rf_we is high.

Function
REQ-013 SHALL accept an A entry {a_rd, a_data} at a rising edge with a_valid&&a_ready; B likewise.
REQ-014 SHALL drive a_ready = !A_full and b_ready = !B_full, with no combinational dependence on the valids.
REQ-015 SHALL NOT pass through a full queue: a pop in the same cycle does not raise ready until the next cycle.
REQ-016 SHALL preserve FIFO order within each requester; cross-requester order follows arbitration only.
REQ-017 SHALL arbitrate round-robin each cycle among non-empty queue heads: if both are non-empty, grant the requester not granted last; if one is non-empty, grant it.
REQ-018 SHALL pop the granted head at the rising edge and load rf_rw/rf_busw from it at the same edge.
REQ-019 SHALL set rf_we to 1 at that edge, or to 0 if the head rd==0; an x0 write consumes its slot and toggles priority.
REQ-020 SHALL clear rf_we to 0, holding rf_rw/rf_busw, at an edge with both queues empty.
REQ-021 SHALL give latency: entry accepted at edge N is earliest popped at edge N+1, rf_we high N+1..N+2, and the register file writes at N+2.
REQ-022 SHALL sustain throughput of one write per cycle.
REQ-023 SHALL allow a queue to push and pop simultaneously with its occupancy unchanged.
REQ-024 SHALL wrap queue pointers modulo FIFO_DEPTH, with a separate count or extra pointer bit distinguishing full from empty.

Reset
REQ-025 SHALL, on rst_n low, immediately flush both queues and set rf_we=0, rf_rw=0, rf_busw=0, busy=0, priority=A, a_ready=b_ready=1.
REQ-026 SHALL discard in-flight entries on reset mid-operation, with no partial write issued.
REQ-027 SHALL accept the first request at the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro REG_WB_ARBITER_BYPASS_EN defined, add ports q_addr (input, 5), q_hit (output, 1) and q_data (output, 32), all combinational.
REQ-029 SHALL, with the macro defined, set q_hit=1 iff q_addr!=0 and q_addr matches any pending entry or the output stage with rf_we=1.
REQ-030 SHALL, with the macro defined, source q_data by priority from the youngest A match, then the youngest B match, then the output stage; q_data=0 when q_hit=0.
REQ-031 SHALL, without the macro, omit these ports and all match logic, with all other behaviour identical.

Verification
REQ-032 SHALL verify single write: A pushes rd=5, data=0xDEADBEEF at edge 1 -> rf_we=1, rf_rw=5, rf_busw=0xDEADBEEF between edges 2 and 3; busy low after edge 3.
REQ-033 SHALL verify contention: A(rd=1, 0x11) and B(rd=2, 0x22) both push at edge 1 -> outputs A at edge 2, B at edge 3; then a further A and B push -> B no longer favoured, A granted before B alternates.
REQ-034 SHALL verify full queue: A pushes 3 entries with B idle and nothing popping (hold via priority on B-stream) -> a_ready low once 2 are queued; the 3rd is held until ready returns; all 3 written in order.
REQ-035 SHALL verify x0: A pushes rd=0, data=0xFFFFFFFF -> slot consumed, rf_we stays 0, next entry written on the following cycle.
REQ-036 SHALL verify async reset: rst_n pulsed low mid-cycle with 2 entries queued -> outputs zero immediately; after release no write of the flushed entries occurs.
REQ-037 SHALL verify bypass, with REG_WB_ARBITER_BYPASS_EN only: B queues rd=7, 0x77 and q_addr=7 -> q_hit=1, q_data=0x77; q_addr=0 -> q_hit=0.
